// File: rtl/carry_select_subtractor.sv
// Pipelined carry-select subtractor: diff = a - b - bin, one block of BLOCK bits resolved per stage.
// Optional signed-overflow output enabled by defining CSS_OVERFLOW_EN.
module carry_select_subtractor #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CSS_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / BLOCK;

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // the whole pipe advances together when the output slot is empty or being taken.
  logic adv;

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] diff_q  [STAGES];
  logic [WIDTH-1:0] diff_d  [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];

  logic             src_valid [STAGES];
  logic [WIDTH-1:0] src_diff  [STAGES];
  logic [WIDTH-1:0] src_a     [STAGES];
  logic [WIDTH-1:0] src_b     [STAGES];
  logic             src_carry [STAGES];
  logic [BLOCK:0]   blk_sum   [STAGES];

`ifdef CSS_OVERFLOW_EN
  logic sa_q  [STAGES];
  logic sa_d  [STAGES];
  logic sb_q  [STAGES];
  logic sb_d  [STAGES];
  logic src_sa [STAGES];
  logic src_sb [STAGES];
`endif

  // Both carry-in candidates are formed side by side; the registered carry only picks one.
  function automatic logic [BLOCK:0] block_sum(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y_n,
                                               input logic             cin);
    logic [BLOCK:0] sum0;
    logic [BLOCK:0] sum1;
    sum0 = {1'b0, x} + {1'b0, y_n};
    sum1 = {1'b0, x} + {1'b0, y_n} + {{BLOCK{1'b0}}, 1'b1};
    return cin ? sum1 : sum0;
  endfunction

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign diff      = diff_q[STAGES-1];
  assign bout      = ~carry_q[STAGES-1];

`ifdef CSS_OVERFLOW_EN
  assign ovf = (sa_q[STAGES-1] ^ sb_q[STAGES-1]) & (diff_q[STAGES-1][WIDTH-1] ^ sa_q[STAGES-1]);
`endif

  // Stage 0 is fed from the ports; every later stage from its predecessor's registers.
  always_comb begin
    src_valid[0] = in_valid;
    src_diff[0]  = '0;
    src_a[0]     = a;
    src_b[0]     = b;
    src_carry[0] = ~bin;
`ifdef CSS_OVERFLOW_EN
    src_sa[0]    = a[WIDTH-1];
    src_sb[0]    = b[WIDTH-1];
`endif
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_diff[k]  = diff_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_carry[k] = carry_q[k-1];
`ifdef CSS_OVERFLOW_EN
      src_sa[k]    = sa_q[k-1];
      src_sb[k]    = sb_q[k-1];
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      blk_sum[k] = block_sum(src_a[k][k*BLOCK +: BLOCK], ~src_b[k][k*BLOCK +: BLOCK], src_carry[k]);
    end
  end

  // Data only loads behind a valid token, so bubbles never disturb diff/bout.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      diff_d[k]  = diff_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      carry_d[k] = carry_q[k];
`ifdef CSS_OVERFLOW_EN
      sa_d[k]    = sa_q[k];
      sb_d[k]    = sb_q[k];
`endif
      if (adv) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          a_d[k]                      = src_a[k];
          b_d[k]                      = src_b[k];
          diff_d[k]                   = src_diff[k];
          diff_d[k][k*BLOCK +: BLOCK] = blk_sum[k][BLOCK-1:0];
          carry_d[k]                  = blk_sum[k][BLOCK];
`ifdef CSS_OVERFLOW_EN
          sa_d[k]                     = src_sa[k];
          sb_d[k]                     = src_sb[k];
`endif
        end
      end
    end
  end

  // Carry resets to 1 so that bout (its inverse) reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        diff_q[k]  <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        carry_q[k] <= 1'b1;
`ifdef CSS_OVERFLOW_EN
        sa_q[k]    <= 1'b0;
        sb_q[k]    <= 1'b0;
`endif
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        diff_q[k]  <= diff_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        carry_q[k] <= carry_d[k];
`ifdef CSS_OVERFLOW_EN
        sa_q[k]    <= sa_d[k];
        sb_q[k]    <= sb_d[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_carry_select_subtractor.sv
// Bench for carry_select_subtractor: arithmetic reference model, directed cases, random traffic.
module tb_carry_select_subtractor;
  localparam int WIDTH = 16;
  localparam int BLOCK = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf_w;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [17:0] exp_q[$];
  logic [15:0] log_diff[$];
  logic        log_bout[$];
  int          log_cyc[$];

  logic        fresh;
  logic        prev_stall;
  logic [17:0] prev_out;

`ifdef CSS_OVERFLOW_EN
  logic ovf;
  assign ovf_w = ovf;
`else
  assign ovf_w = 1'b0;
`endif

  carry_select_subtractor #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef CSS_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // reference model: plain integer arithmetic, {ovf, bout, diff}
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    longint r;
    int     sr;
    logic   o;
    logic [15:0] d;
    r  = longint'(x) - longint'(y) - longint'(bi);
    d  = r[15:0];
    sr = int'($signed(x)) - int'($signed(y)) - int'(bi);
`ifdef CSS_OVERFLOW_EN
    o  = (sr > 32767) || (sr < -32768);
`else
    o  = 1'b0;
`endif
    return {o, (r < 0), d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      fresh      = 1'b1;
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        fresh = 1'b0;
        if (prev_stall) check("stall_hold", {ovf_w, bout, diff}, prev_out);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got diff %0h, expected no result", diff);
        end else begin
          check("result", {ovf_w, bout, diff}, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            log_diff.push_back(diff);
            log_bout.push_back(bout);
            log_cyc.push_back(cyc);
          end
        end
      end else if (fresh) begin
        check("idle_zero", {ovf_w, bout, diff}, 32'h0);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {ovf_w, bout, diff};
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic bi);
    int n;
    in_valid = 1'b1;
    a = x;
    b = y;
    bin = bi;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic run_one(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic bi, input logic [15:0] ed, input logic eb, input logic eo);
    int n;
    send(x, y, bi);
    wait_valid(n);
    check({name, "_latency"}, 32'(n), 32'd4);
    check({name, "_diff"}, diff, ed);
    check({name, "_bout"}, bout, eb);
`ifdef CSS_OVERFLOW_EN
    check({name, "_ovf"}, ovf, eo);
`else
    if (eo) check({name, "_ovf_unused"}, ovf_w, 1'b0);
`endif
    step();
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] c [4];
    c[0] = 16'h0000; c[1] = 16'hFFFF; c[2] = 16'h8000; c[3] = 16'h7FFF;
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
    return 16'($urandom_range(0, 65535));
  endfunction

  initial begin
    int stale;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_diff", diff, 16'h0);
    check("reset_bout", bout, 1'b0);
    check("reset_ovf", ovf_w, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1'b1);
    step();

    out_ready = 1'b1;
    run_one("basic", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_one("underflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_one("ripple", 16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0, 1'b0);
    run_one("ovf_pos", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_one("ovf_neg", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFE, 1'b0, 1'b0);

    // back-to-back
    log_diff.delete(); log_bout.delete(); log_cyc.delete();
    for (int i = 0; i < 8; i++) send(16'(i), 16'h0010, 1'b0);
    repeat (8) step();
    check("b2b_count", 32'(log_diff.size()), 32'd8);
    if (log_diff.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("b2b_diff", log_diff[i], 16'hFFF0 + 16'(i));
        check("b2b_bout", log_bout[i], 1'b1);
        check("b2b_gap", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
      end
    end

    // backpressure
    log_diff.delete(); log_bout.delete(); log_cyc.delete();
    for (int i = 1; i <= 4; i++) send(16'(100 * i), 16'(i), 1'b0);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_diff", diff, 16'h0063);
    end
    step();
    out_ready = 1'b1;
    repeat (6) step();
    check("bp_count", 32'(log_diff.size()), 32'd4);
    if (log_diff.size() == 4) begin
      for (int i = 0; i < 4; i++) check("bp_order", log_diff[i], 16'(99 * (i + 1)));
    end

    // reset mid-stream
    send(16'h0050, 16'h0001, 1'b0);
    send(16'h0060, 16'h0002, 1'b0);
    send(16'h0070, 16'h0003, 1'b0);
    step();
    check("pre_reset_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("reset_immediate", out_valid, 1'b0);
    check("reset_diff_clear", diff, 16'h0);
    repeat (2) step();
    rst = 1'b0;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", 32'(stale), 32'd0);
    step();
    run_one("post_reset", 16'h0009, 16'h0004, 1'b0, 16'h0005, 1'b0, 1'b0);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = pick();
      b         = pick();
      bin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
